ysyx_23060096_ifu: RTL

YSYX_23060096_IFU -- requirements
Module: ysyx_23060096_ifu

---
 rtl/ysyx_23060096_ifu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: issues sequential fetches into an in-order fetch queue and hands instructions to decode.
// Optional macro YSYX_23060096_IFU_ALIGN_CHK_EN halts fetch on a misaligned redirect target.
module ysyx_23060096_ifu #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = XLEN'(32'h8000_0000),
   parameter int                DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [31:0]     q_inst [DEPTH];
   logic [DEPTH-1:0] q_filled;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   fptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   unfilled;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   outstanding;
   logic [CW:0]     inflight;
   logic            run;
   logic            halted;
   logic            alloc;
   logic            fill;
   logic            pop;
   logic            rsp_consumed;
   logic [XLEN-1:0] target;

`ifdef YSYX_23060096_IFU_ALIGN_CHK_EN
   assign target = redirect_pc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         halted <= 1'b0;
      end else if (redirect_valid) begin
         halted <= |redirect_pc[1:0];
      end
   end
`else
   logic unused_pc_bits;
   assign unused_pc_bits = ^redirect_pc[1:0];
   assign target         = {redirect_pc[XLEN-1:2], 2'b00};
   assign halted         = 1'b0;
`endif

   assign misalign = halted;

   // Pending drops still occupy memory-side slots, so they count against the queue budget.
   assign inflight       = {1'b0, count} + {1'b0, drop};
   assign imem_req_valid = run & ~halted & ~redirect_valid & (inflight < DEPTH_W);
   assign imem_req_addr  = fpc;
   assign alloc          = imem_req_valid & imem_req_ready;

   assign fill         = imem_rsp_valid & (drop == '0) & (unfilled != '0);
   assign outstanding  = drop + unfilled;
   assign rsp_consumed = imem_rsp_valid & (outstanding != '0);

   assign inst_valid = q_filled[head];
   assign inst       = inst_valid ? q_inst[head] : 32'h0;
   assign inst_pc    = inst_valid ? q_pc[head] : '0;
   assign pop        = inst_valid & inst_ready;

   // A response landing in the redirect cycle is discarded but still retires one outstanding slot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fpc      <= RESET_PC;
         run      <= 1'b0;
         head     <= '0;
         tail     <= '0;
         fptr     <= '0;
         count    <= '0;
         unfilled <= '0;
         drop     <= '0;
         q_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_inst[i] <= '0;
         end
      end else begin
         run <= 1'b1;
         if (redirect_valid) begin
            fpc      <= target;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            count    <= '0;
            unfilled <= '0;
            q_filled <= '0;
            drop     <= outstanding - CW'(rsp_consumed);
         end else begin
            if (alloc) begin
               q_pc[tail] <= fpc;
               tail       <= tail + PW'(1);
               fpc        <= fpc + XLEN'(4);
            end
            if (fill) begin
               q_inst[fptr]   <= imem_rsp_data;
               q_filled[fptr] <= 1'b1;
               fptr           <= fptr + PW'(1);
            end else if (imem_rsp_valid && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
            if (pop) begin
               q_filled[head] <= 1'b0;
               head           <= head + PW'(1);
            end
            count    <= count + CW'(alloc) - CW'(pop);
            unfilled <= unfilled + CW'(alloc) - CW'(fill);
         end
      end
   end

endmodule
